sha2_hash_state_mc: RTL and testbench

- Multi-context SHA-2 intermediate-hash store for the hash compute unit (HCU).
- Holds H0..H7 for NUM_CTX independent message contexts, each with its own SHA type.
- Handles three commands: INIT (load the FIPS 180-4 IV), UPDATE (H += working vars a..h, one shared adder, one word per cycle) and READ (stream the truncated digest over a valid/ready port).

---
 rtl/sha2_hash_state_mc.sv | 250 +++++++++++++++++++++++++
 tb/tb_sha2_hash_state_mc.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_hash_state_mc.sv
// ---------------------------------------------------------------------------
// sha2_hash_state_mc
//
// Multi-context SHA-2 intermediate-hash store for the hash compute unit.
// Each context holds H0..H7, its SHA type and a valid flag. Commands:
//   INIT   load the FIPS 180-4 IV for cmd_type
//   UPDATE H[k] += working variable k, one word per cycle through one adder
//   READ   stream the truncated digest over a valid/ready port
//
// Ports
//   clk, reset         system clock, async active-high reset
//   cmd_valid/ready    command handshake (ready only while idle)
//   cmd_op             00 INIT, 01 UPDATE, 10 READ, 11 reserved
//   cmd_ctx            target context
//   cmd_type           00 SHA-224, 01 SHA-256, 10 SHA-384, 11 SHA-512 (INIT)
//   ah_in              working vars a..h, a in [511:448], h in [63:0]
//   dig_valid/ready    digest word handshake
//   dig_data/last      digest word, last-word marker
//   upd_done           one-cycle pulse when an UPDATE completes
//   err                one-cycle pulse on a rejected command
//
// 32-bit modes keep each word in [63:32] with [31:0] held at zero.
// ---------------------------------------------------------------------------
module sha2_hash_state_mc #(
    parameter  int NUM_CTX = 4,
    localparam int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CTX_W-1:0] cmd_ctx,
    input  logic [1:0]       cmd_type,
    input  logic [511:0]     ah_in,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [63:0]      dig_data,
    output logic             dig_last,
    output logic             upd_done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_READ
    } state_t;

    state_t             state;
    logic [63:0]        h_mem    [NUM_CTX][8];
    logic [1:0]         type_mem [NUM_CTX];
    logic [NUM_CTX-1:0] vld_mem;

    logic [CTX_W-1:0]   ctx_q;
    logic [1:0]         type_q;
    logic [2:0]         k_q;
    logic [511:0]       ah_q;

    logic               ctx_ok;
    logic               ctx_vld;
    logic [1:0]         ctx_type;
    logic [63:0]        add_word;

    function automatic logic [63:0] iv_word(input logic [1:0] t, input logic [2:0] i);
        logic [63:0] v;
        v = 64'h0;
        case (t)
            2'b00: case (i)
                3'd0: v = 64'hc1059ed8_00000000;
                3'd1: v = 64'h367cd507_00000000;
                3'd2: v = 64'h3070dd17_00000000;
                3'd3: v = 64'hf70e5939_00000000;
                3'd4: v = 64'hffc00b31_00000000;
                3'd5: v = 64'h68581511_00000000;
                3'd6: v = 64'h64f98fa7_00000000;
                default: v = 64'hbefa4fa4_00000000;
            endcase
            2'b01: case (i)
                3'd0: v = 64'h6a09e667_00000000;
                3'd1: v = 64'hbb67ae85_00000000;
                3'd2: v = 64'h3c6ef372_00000000;
                3'd3: v = 64'ha54ff53a_00000000;
                3'd4: v = 64'h510e527f_00000000;
                3'd5: v = 64'h9b05688c_00000000;
                3'd6: v = 64'h1f83d9ab_00000000;
                default: v = 64'h5be0cd19_00000000;
            endcase
            2'b10: case (i)
                3'd0: v = 64'hcbbb9d5d_c1059ed8;
                3'd1: v = 64'h629a292a_367cd507;
                3'd2: v = 64'h9159015a_3070dd17;
                3'd3: v = 64'h152fecd8_f70e5939;
                3'd4: v = 64'h67332667_ffc00b31;
                3'd5: v = 64'h8eb44a87_68581511;
                3'd6: v = 64'hdb0c2e0d_64f98fa7;
                default: v = 64'h47b5481d_befa4fa4;
            endcase
            default: case (i)
                3'd0: v = 64'h6a09e667_f3bcc908;
                3'd1: v = 64'hbb67ae85_84caa73b;
                3'd2: v = 64'h3c6ef372_fe94f82b;
                3'd3: v = 64'ha54ff53a_5f1d36f1;
                3'd4: v = 64'h510e527f_ade682d1;
                3'd5: v = 64'h9b05688c_2b3e6c1f;
                3'd6: v = 64'h1f83d9ab_fb41bd6b;
                default: v = 64'h5be0cd19_137e2179;
            endcase
        endcase
        return v;
    endfunction

    // Index of the final digest word: 224->6, 256->7, 384->5, 512->7
    function automatic logic [2:0] last_idx(input logic [1:0] t);
        case (t)
            2'b00:   return 3'd6;
            2'b10:   return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [63:0] fmt(input logic [63:0] w, input logic [1:0] t);
        return t[1] ? w : {w[63:32], 32'h0};
    endfunction

    // Decode by comparison so an out-of-range ctx (non-power-of-2 NUM_CTX)
    // never indexes the arrays and simply reads as not valid.
    always_comb begin
        ctx_ok   = 1'b0;
        ctx_vld  = 1'b0;
        ctx_type = 2'b00;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (cmd_ctx == CTX_W'(i)) begin
                ctx_ok   = 1'b1;
                ctx_vld  = vld_mem[i];
                ctx_type = type_mem[i];
            end
        end
    end

    // Shared adder; ah_q is shifted left each cycle so word k is always on top.
    always_comb begin
        add_word = h_mem[ctx_q][k_q] + ah_q[511:448];
        if (!type_q[1]) begin
            add_word = {h_mem[ctx_q][k_q][63:32] + ah_q[511:480], 32'h0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            dig_valid <= 1'b0;
            dig_data  <= 64'h0;
            dig_last  <= 1'b0;
            upd_done  <= 1'b0;
            err       <= 1'b0;
            ctx_q     <= '0;
            type_q    <= 2'b00;
            k_q       <= 3'd0;
            ah_q      <= '0;
            vld_mem   <= '0;
            for (int c = 0; c < NUM_CTX; c++) begin
                type_mem[c] <= 2'b00;
                for (int w = 0; w < 8; w++) begin
                    h_mem[c][w] <= 64'h0;
                end
            end
        end else begin
            upd_done <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            2'b00: begin
                                if (ctx_ok) begin
                                    for (int w = 0; w < 8; w++) begin
                                        h_mem[cmd_ctx][w] <= iv_word(cmd_type, 3'(w));
                                    end
                                    type_mem[cmd_ctx] <= cmd_type;
                                    vld_mem[cmd_ctx]  <= 1'b1;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            2'b01: begin
                                if (ctx_vld) begin
                                    ah_q      <= ah_in;
                                    ctx_q     <= cmd_ctx;
                                    type_q    <= ctx_type;
                                    k_q       <= 3'd0;
                                    state     <= S_ADD;
                                    cmd_ready <= 1'b0;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            2'b10: begin
                                if (ctx_vld) begin
                                    ctx_q     <= cmd_ctx;
                                    type_q    <= ctx_type;
                                    k_q       <= 3'd0;
                                    state     <= S_READ;
                                    cmd_ready <= 1'b0;
                                    dig_valid <= 1'b1;
                                    dig_data  <= fmt(h_mem[cmd_ctx][0], ctx_type);
                                    dig_last  <= 1'b0;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                S_ADD: begin
                    h_mem[ctx_q][k_q] <= add_word;
                    ah_q              <= ah_q << 64;
                    k_q               <= k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                        upd_done  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (dig_ready) begin
                        if (dig_last) begin
                            dig_valid <= 1'b0;
                            dig_last  <= 1'b0;
                            dig_data  <= 64'h0;
                            state     <= S_IDLE;
                            cmd_ready <= 1'b1;
                        end else begin
                            k_q      <= k_q + 3'd1;
                            dig_data <= fmt(h_mem[ctx_q][k_q + 3'd1], type_q);
                            dig_last <= ((k_q + 3'd1) == last_idx(type_q));
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_hash_state_mc.sv
module tb_sha2_hash_state_mc;
    localparam int NUM_CTX = 4;
    localparam int CTX_W   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CTX_W-1:0] cmd_ctx;
    logic [1:0]       cmd_type;
    logic [511:0]     ah_in;
    logic             dig_valid;
    logic             dig_ready;
    logic [63:0]      dig_data;
    logic             dig_last;
    logic             upd_done;
    logic             err;

    sha2_hash_state_mc #(.NUM_CTX(NUM_CTX)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ctx(cmd_ctx), .cmd_type(cmd_type), .ah_in(ah_in),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
        .dig_last(dig_last), .upd_done(upd_done), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: digest state per context
    logic [31:0] iv224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                               32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    logic [31:0] iv256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [63:0] iv384 [8] = '{64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17,
                               64'h152fecd8f70e5939, 64'h67332667ffc00b31, 64'h8eb44a8768581511,
                               64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
    logic [63:0] iv512 [8] = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
                               64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                               64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

    logic [63:0] m_h    [NUM_CTX][8];
    logic [1:0]  m_type [NUM_CTX];
    bit          m_vld  [NUM_CTX];

    function automatic logic [63:0] m_iv(input logic [1:0] t, input int i);
        case (t)
            2'b00:   return {iv224[i], 32'h0};
            2'b01:   return {iv256[i], 32'h0};
            2'b10:   return iv384[i];
            default: return iv512[i];
        endcase
    endfunction

    function automatic int m_nwords(input logic [1:0] t);
        case (t)
            2'b00:   return 7;
            2'b10:   return 6;
            default: return 8;
        endcase
    endfunction

    function automatic logic [63:0] m_add(input logic [63:0] h, input logic [63:0] a, input logic [1:0] t);
        logic [31:0] hi;
        if (t[1]) return h + a;
        hi = h[63:32] + a[63:32];
        return {hi, 32'h0};
    endfunction

    task automatic m_clear();
        for (int c = 0; c < NUM_CTX; c++) begin
            m_vld[c]  = 1'b0;
            m_type[c] = 2'b00;
            for (int w = 0; w < 8; w++) m_h[c][w] = 64'h0;
        end
    endtask

    // Per-cycle expected outputs, written by stimulus, compared at negedge
    logic        e_ready, e_dv, e_last, e_upd, e_err;
    logic [63:0] e_data;
    bit          chk_en;
    int          n_checks = 0;
    int          n_errors = 0;

    // Literal checks are queued here and evaluated by the compare process
    string       lq_name [$];
    logic [63:0] lq_act  [$];
    logic [63:0] lq_exp  [$];

    task automatic lit(input string nm, input logic [63:0] a, input logic [63:0] e);
        lq_name.push_back(nm);
        lq_act.push_back(a);
        lq_exp.push_back(e);
    endtask

    task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("cmd_ready", 64'(cmd_ready), 64'(e_ready));
            cmp("dig_valid", 64'(dig_valid), 64'(e_dv));
            cmp("upd_done",  64'(upd_done),  64'(e_upd));
            cmp("err",       64'(err),       64'(e_err));
            if (e_dv) begin
                cmp("dig_data", dig_data, e_data);
                cmp("dig_last", 64'(dig_last), 64'(e_last));
            end
        end
        while (lq_name.size() > 0) begin
            cmp(lq_name.pop_front(), lq_act.pop_front(), lq_exp.pop_front());
        end
    end

    // Stimulus helpers
    logic [63:0] rd_buf [8];
    int          rd_n;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_ready = 1'b1; e_dv = 1'b0; e_last = 1'b0;
        e_upd = 1'b0; e_err = 1'b0; e_data = 64'h0;
    endtask

    task automatic issue(input logic [1:0] op, input int ctx, input logic [1:0] t, input logic [511:0] ah);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ctx   = CTX_W'(ctx);
        cmd_type  = t;
        ah_in     = ah;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_init(input int ctx, input logic [1:0] t);
        issue(2'b00, ctx, t, '0);
        for (int w = 0; w < 8; w++) m_h[ctx][w] = m_iv(t, w);
        m_type[ctx] = t;
        m_vld[ctx]  = 1'b1;
    endtask

    task automatic do_err(input logic [1:0] op, input int ctx);
        issue(op, ctx, 2'b00, {8{64'h0123456789abcdef}});
        e_err = 1'b1;
        tick();
        e_err = 1'b0;
    endtask

    task automatic do_update(input int ctx, input logic [511:0] ah);
        issue(2'b01, ctx, 2'b00, ah);
        e_ready = 1'b0;
        repeat (8) tick();
        e_ready = 1'b1;
        e_upd   = 1'b1;
        tick();
        e_upd   = 1'b0;
        for (int w = 0; w < 8; w++)
            m_h[ctx][w] = m_add(m_h[ctx][w], ah[511 - 64*w -: 64], m_type[ctx]);
    endtask

    // stall=1: dig_ready low on even cycles, high on odd cycles
    task automatic do_read(input int ctx, input bit stall);
        int k;
        int cyc;
        int nw;
        bit rdy;
        nw  = m_nwords(m_type[ctx]);
        k   = 0;
        cyc = 0;
        rd_n = 0;
        issue(2'b10, ctx, 2'b00, '0);
        while (k < nw) begin
            rdy       = stall ? (cyc % 2 == 1) : 1'b1;
            e_ready   = 1'b0;
            e_dv      = 1'b1;
            e_data    = m_h[ctx][k];
            e_last    = (k == nw - 1);
            dig_ready = rdy;
            #3;
            if (rdy) begin
                rd_buf[k] = dig_data;
                rd_n++;
                k++;
            end
            tick();
            cyc++;
        end
        dig_ready = 1'b0;
        idle_exp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_ctx   = '0;
        cmd_type  = 2'b00;
        ah_in     = '0;
        dig_ready = 1'b0;
        chk_en    = 1'b0;
        idle_exp();
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        lit("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        lit("rst_dig_valid", 64'(dig_valid), 64'h0);
        lit("rst_dig_data",  dig_data,       64'h0);
        lit("rst_upd_done",  64'(upd_done),  64'h0);
        lit("rst_err",       64'(err),       64'h0);
        reset  = 1'b0;
        chk_en = 1'b1;
        tick();

        // SHA-256 IV readback
        do_init(0, 2'b01);
        do_read(0, 1'b0);
        lit("sha256_n",  64'(rd_n), 64'd8);
        lit("sha256_w0", rd_buf[0], 64'h6a09e667_00000000);
        lit("sha256_w7", rd_buf[7], 64'h5be0cd19_00000000);

        // SHA-512 with all-ones working vars wraps each word by -1
        do_init(1, 2'b11);
        do_update(1, {8{64'hFFFFFFFF_FFFFFFFF}});
        do_read(1, 1'b0);
        lit("sha512_w0", rd_buf[0], 64'h6a09e667_f3bcc907);
        lit("sha512_w7", rd_buf[7], 64'h5be0cd19_137e2178);

        // SHA-224: no carry into the lower half, 7 words
        do_init(2, 2'b00);
        do_update(2, {64'hFFFFFFFF_FFFFFFFF, 448'h0});
        do_read(2, 1'b0);
        lit("sha224_n",  64'(rd_n), 64'd7);
        lit("sha224_w0", rd_buf[0], 64'hc1059ed7_00000000);
        lit("sha224_w1", rd_buf[1], 64'h367cd507_00000000);

        // Rejected commands
        do_err(2'b01, 3);
        do_err(2'b10, 3);
        do_err(2'b11, 0);
        do_err(2'b11, 2);
        do_read(0, 1'b0);
        do_read(1, 1'b0);
        do_read(2, 1'b0);

        // 32-bit carry out of the top is dropped, lower ah bits ignored
        do_update(0, {64'h96000000_12345678, 448'h0});
        do_read(0, 1'b0);
        lit("sha256_upd_w0", rd_buf[0], 64'h0009e667_00000000);

        // Re-INIT of a valid context restores its IV
        do_init(1, 2'b11);
        do_read(1, 1'b0);
        lit("reinit_w0", rd_buf[0], 64'h6a09e667_f3bcc908);

        // SHA-384 with a stalling consumer
        do_init(3, 2'b10);
        do_read(3, 1'b1);
        lit("sha384_n",  64'(rd_n), 64'd6);
        lit("sha384_w0", rd_buf[0], 64'hcbbb9d5d_c1059ed8);
        lit("sha384_w5", rd_buf[5], 64'h8eb44a87_68581511);

        // Reset during ADD cycle 4
        issue(2'b01, 2, 2'b00, {8{64'h00000001_00000001}});
        e_ready = 1'b0;
        repeat (3) tick();
        chk_en = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        lit("midrst_cmd_ready", 64'(cmd_ready), 64'h1);
        lit("midrst_dig_valid", 64'(dig_valid), 64'h0);
        lit("midrst_dig_data",  dig_data,       64'h0);
        lit("midrst_upd_done",  64'(upd_done),  64'h0);
        lit("midrst_err",       64'(err),       64'h0);
        m_clear();
        idle_exp();
        repeat (2) tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        tick();
        do_err(2'b10, 2);
        do_err(2'b10, 0);
        do_init(2, 2'b01);
        do_read(2, 1'b0);
        lit("post_rst_w0", rd_buf[0], 64'h6a09e667_00000000);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
